rv_div: RTL and testbench

RV_DIV -- requirements
Module: rv_div

---
 rtl/rv_div_pkg.sv | 30 +++
 rtl/rv_div_step.sv | 13 +
 rtl/rv_div.sv | 119 +++++++++++
 tb/tb_rv_div.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_div_pkg.sv
// rv_div_pkg: shared encodings and helpers for the iterative RISC-V divider.
package rv_div_pkg;
    typedef enum logic [2:0] {
        OP_DIV  = 3'b100,
        OP_DIVU = 3'b101,
        OP_REM  = 3'b110,
        OP_REMU = 3'b111
    } div_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } div_state_t;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    function automatic logic is_signed_op(input div_op_t op);
        return op == OP_DIV || op == OP_REM;
    endfunction

    function automatic logic is_rem_op(input div_op_t op);
        return op == OP_REM || op == OP_REMU;
    endfunction

    function automatic logic [31:0] abs32(input logic [31:0] x, input logic sgn);
        return (sgn && x[31]) ? -x : x;
    endfunction
endpackage

// File: rtl/rv_div_step.sv
// rv_div_step: one restoring-division iteration (shift in next dividend bit, trial subtract).
module rv_div_step (
    input  logic [32:0] rem_i,
    input  logic [31:0] quo_i,
    input  logic [31:0] dsr_i,
    output logic [32:0] rem_o,
    output logic [31:0] quo_o
);
    logic [33:0] trial;
    assign trial = {1'b0, rem_i[31:0], quo_i[31]} - {2'b00, dsr_i};
    assign rem_o = trial[33] ? {rem_i[31:0], quo_i[31]} : trial[32:0];
    assign quo_o = {quo_i[30:0], ~trial[33]};
endmodule

// File: rtl/rv_div.sv
// rv_div: multi-cycle RV32M DIV/DIVU/REM/REMU unit with stall, flush and early special cases.
module rv_div
    import rv_div_pkg::*;
#(
    parameter bit EARLY_SPECIAL = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_flush,
    input  logic        i_start,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_dividend,
    input  logic [31:0] i_divisor,
    output logic        o_busy,
    output logic        o_valid,
    output logic [31:0] o_result
);
    div_state_t  state_q, state_d;
    div_op_t     op_q, op_d, op_in;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d, dsr_q, dsr_d, result_q, result_d;
    logic [32:0] rem_q, rem_d, step_rem;
    logic [31:0] step_quo, spec_quo, spec_rem, fix_quo, fix_rem;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, valid_q, valid_d;
    logic        sgn_in, accept, div_zero, overflow, special;

    assign op_in    = div_op_t'(i_funct3);
    assign sgn_in   = is_signed_op(op_in);
    assign accept   = i_start && !i_flush && (state_q == S_IDLE || state_q == S_DONE);
    assign div_zero = i_divisor == '0;
    assign overflow = sgn_in && i_dividend == INT_MIN && i_divisor == '1;
    assign special  = EARLY_SPECIAL && (div_zero || overflow);
    assign spec_quo = div_zero ? '1 : INT_MIN;
    assign spec_rem = div_zero ? i_dividend : '0;
    assign fix_quo  = neg_quo_q ? -quo_q : quo_q;
    assign fix_rem  = neg_rem_q ? -rem_q[31:0] : rem_q[31:0];

    assign o_busy   = accept || state_q == S_CALC || state_q == S_FIX;
    assign o_valid  = valid_q;
    assign o_result = result_q;

    rv_div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dsr_i (dsr_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        valid_d   = 1'b0;
        if (i_flush) begin
            state_d = S_IDLE;
        end else if (accept) begin
            op_d      = op_in;
            cnt_d     = '0;
            quo_d     = abs32(i_dividend, sgn_in);
            dsr_d     = abs32(i_divisor, sgn_in);
            rem_d     = '0;
            // a zero divisor yields all-ones quotient regardless of dividend sign
            neg_quo_d = sgn_in && (i_dividend[31] ^ i_divisor[31]) && !div_zero;
            neg_rem_d = sgn_in && i_dividend[31];
            state_d   = special ? S_DONE : S_CALC;
            valid_d   = special;
            result_d  = special ? (is_rem_op(op_in) ? spec_rem : spec_quo) : result_q;
        end else begin
            case (state_q)
                S_CALC: begin
                    quo_d   = step_quo;
                    rem_d   = step_rem;
                    cnt_d   = cnt_q + 5'd1;
                    state_d = (cnt_q == 5'd31) ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    state_d  = S_DONE;
                    valid_d  = 1'b1;
                    result_d = is_rem_op(op_q) ? fix_rem : fix_quo;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= div_op_t'(3'b000);
            cnt_q     <= '0;
            quo_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            valid_q   <= valid_d;
        end
    end
endmodule

// File: tb/tb_rv_div.sv
// tb_rv_div: scoreboard bench for rv_div covering timing, signed/unsigned results, specials, flush and reset.
module tb_rv_div;
    logic        i_clk = 1'b0, i_reset_n = 1'b0, i_flush = 1'b0, i_start = 1'b0;
    logic [2:0]  i_funct3 = 3'b101;
    logic [31:0] i_dividend = '0, i_divisor = '0;
    logic        o_busy, o_valid;
    logic [31:0] o_result;
    int          n_vec = 0, n_bad = 0;
    logic [31:0] exp_q[$];

    rv_div #(.EARLY_SPECIAL(1'b1)) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_flush    (i_flush),
        .i_start    (i_start),
        .i_funct3   (i_funct3),
        .i_dividend (i_dividend),
        .i_divisor  (i_divisor),
        .o_busy     (o_busy),
        .o_valid    (o_valid),
        .o_result   (o_result)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q, r;
        logic        s;
        s = ~f3[0];
        if (b == 0) begin
            q = '1;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return f3[1] ? r : q;
    endfunction

    task automatic launch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, output int lat);
        exp_q.push_back(model(f3, a, b));
        lat = (b == 0 || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
        i_funct3   = f3;
        i_dividend = a;
        i_divisor  = b;
        i_start    = 1'b1;
    endtask

    // Follows one operation from cycle `first` until its strobe; cycle 0 is the accept cycle.
    task automatic await(input string name, input int lat, input int first, input bit check_after);
        int          cyc, busy_bad;
        logic [31:0] exp, held;
        busy_bad = 0;
        cyc = first;
        if (first == 1) begin
            @(posedge i_clk);
            #1 i_start = 1'b0;
        end
        forever begin
            @(negedge i_clk);
            if (o_busy !== (cyc < lat)) busy_bad++;
            if (o_valid === 1'b1 || cyc > lat + 4) break;
            @(posedge i_clk);
            #1 i_start = 1'b0;
            cyc++;
        end
        exp = exp_q.pop_front();
        n_vec++;
        if (cyc != lat) begin
            n_bad++;
            $display("FAIL %s latency: got %0d cycles, want %0d", name, cyc, lat);
        end
        n_vec++;
        if (o_valid !== 1'b1 || o_result !== exp) begin
            n_bad++;
            $display("FAIL %s result: valid=%b result=%h, want valid=1 result=%h", name, o_valid, o_result, exp);
        end
        n_vec++;
        if (busy_bad != 0) begin
            n_bad++;
            $display("FAIL %s busy: %0d wrong cycles, want 0", name, busy_bad);
        end
        if (check_after) begin
            held = o_result;
            @(negedge i_clk);
            n_vec++;
            if (o_valid !== 1'b0 || o_result !== held) begin
                n_bad++;
                $display("FAIL %s after: valid=%b result=%h, want valid=0 result=%h", name, o_valid, o_result, held);
            end
        end
    endtask

    task automatic run(input string name, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        int lat;
        @(posedge i_clk);
        #1 launch(f3, a, b, lat);
        await(name, lat, 0, 1'b1);
    endtask

    task automatic expect_idle(input string name, input int cycles, input logic [31:0] held);
        int strobes;
        strobes = 0;
        repeat (cycles) begin
            @(negedge i_clk);
            if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_result !== held) strobes++;
        end
        n_vec++;
        if (strobes != 0) begin
            n_bad++;
            $display("FAIL %s idle: %0d cycles with valid/busy/result activity, want 0", name, strobes);
        end
    endtask

    task automatic test_reset;
        #12;
        n_vec++;
        if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset: valid=%b busy=%b result=%h, want 0 0 0", o_valid, o_busy, o_result);
        end
        #3 i_reset_n = 1'b1;
    endtask

    task automatic test_basic;
        run("divu_100_7", 3'b101, 32'd100, 32'd7);
        n_vec++;
        if (o_result !== 32'd14) begin
            n_bad++;
            $display("FAIL divu_100_7 const: got %h, want 0000000e", o_result);
        end
    endtask

    task automatic test_signed;
        run("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2);
        run("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2);
        run("remu_m7_2",  3'b111, 32'hFFFF_FFF9, 32'd2);
        run("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9);
        run("rem_100_m7", 3'b110, 32'd100, 32'hFFFF_FFF9);
        run("divu_big",   3'b101, 32'hFFFF_FFFF, 32'd1);
        run("remu_small", 3'b111, 32'd3, 32'hFFFF_FFFE);
        run("div_min_2",  3'b100, 32'h8000_0000, 32'd2);
    endtask

    task automatic test_special;
        run("divu_div0", 3'b101, 32'd5, 32'd0);
        run("rem_div0",  3'b110, 32'd5, 32'd0);
        run("div_ndiv0", 3'b100, 32'hFFFF_FFFB, 32'd0);
        run("remu_div0", 3'b111, 32'hDEAD_BEEF, 32'd0);
        run("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
        run("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
        run("divu_novf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF);
    endtask

    task automatic test_random;
        for (int i = 0; i < 6; i++) begin
            logic [2:0]  f3;
            logic [31:0] a, b;
            f3 = 3'($urandom_range(4, 7));
            a  = $urandom;
            b  = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run("random", f3, a, b);
        end
    endtask

    task automatic test_flush;
        int          lat;
        logic [31:0] held;
        held = o_result;
        @(posedge i_clk);
        #1 launch(3'b101, 32'd100, 32'd7, lat);
        void'(exp_q.pop_back());
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (9) @(posedge i_clk);
        #1 i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        expect_idle("flush", 40, held);
        run("divu_9_3", 3'b101, 32'd9, 32'd3);
    endtask

    task automatic test_back_to_back;
        int lat1, lat2, lat3, lat4;
        @(posedge i_clk);
        #1 launch(3'b101, 32'd1000, 32'd3, lat1);
        await("b2b_first", lat1, 0, 1'b0);
        launch(3'b100, 32'hFFFF_FC18, 32'd7, lat2);
        await("b2b_second", lat2, 1, 1'b0);
        launch(3'b110, 32'd7, 32'd0, lat3);
        await("b2b_special1", lat3, 1, 1'b0);
        launch(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, lat4);
        await("b2b_special2", lat4, 1, 1'b1);
    endtask

    task automatic test_reset_mid;
        int lat;
        @(posedge i_clk);
        #1 launch(3'b101, 32'd100, 32'd7, lat);
        void'(exp_q.pop_back());
        @(posedge i_clk);
        #1 i_start = 1'b0;
        repeat (19) @(posedge i_clk);
        #2 i_reset_n = 1'b0;
        #1;
        n_vec++;
        if (o_valid !== 1'b0 || o_result !== 32'h0 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid: valid=%b busy=%b result=%h, want 0 0 0", o_valid, o_busy, o_result);
        end
        i_start = 1'b1;
        #1;
        n_vec++;
        if (o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid busy_follow: busy=%b, want 1", o_busy);
        end
        i_start = 1'b0;
        @(posedge i_clk);
        #3 i_reset_n = 1'b1;
        expect_idle("reset_mid", 40, 32'h0);
        run("post_reset", 3'b101, 32'd9, 32'd3);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_signed;
        test_special;
        test_random;
        test_flush;
        test_back_to_back;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
